// File: rtl/memory_game_pkg.sv
// Shared types and width helpers for the note-memory game engine.
// Pure declarations; no timing or flow control of its own.
package memory_game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAY_ON,
        PLAY_OFF,
        WAIT_KEY,
        KEY_HOLD,
        WIN,
        LOSE
    } game_state_t;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int lives_w(input int lives);
        return $clog2(lives + 1);
    endfunction

endpackage

// File: rtl/memory_game_core_if.sv
// Control/keypad inputs and tone/status outputs of the game core.
// Level and pulse signals only; there is no handshake or backpressure.
interface memory_game_core_if #(
    parameter int NOTE_W  = 4,
    parameter int MAX_LEN = 8,
    parameter int LIVES   = 3
);
    import memory_game_pkg::*;

    localparam int LEN_W   = len_w(MAX_LEN);
    localparam int LIVES_W = lives_w(LIVES);

    logic                      seq_load;
    logic [MAX_LEN*NOTE_W-1:0] seq_data;
    logic                      start;
    logic                      key_valid;
    logic [NOTE_W-1:0]         key_code;
    logic [NOTE_W-1:0]         tone_out;
    logic [NOTE_W-1:0]         led_out;
    logic                      playing;
    logic                      miss_pulse;
    logic [LEN_W-1:0]          round_len;
    logic [LIVES_W-1:0]        lives_left;
    logic                      game_win;
    logic                      game_over;

    modport master (
        output seq_load, seq_data, start, key_valid, key_code,
        input  tone_out, led_out, playing, miss_pulse, round_len, lives_left, game_win, game_over
    );

    modport slave (
        input  seq_load, seq_data, start, key_valid, key_code,
        output tone_out, led_out, playing, miss_pulse, round_len, lives_left, game_win, game_over
    );

endinterface

// File: rtl/game_tick_gen.sv
// Free-running 0..TICK_DIV-1 divider; tick is high in the cycle the count wraps.
// clr restarts the count from 0 on the next edge; no backpressure.
module game_tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/memory_game_core.sv
// Note-memory game: plays a growing stored sequence, then checks key presses against it.
// Tone output is registered (one cycle behind state); inputs are never backpressured.
module memory_game_core
    import memory_game_pkg::*;
#(
    parameter int NOTE_W        = 4,
    parameter int MAX_LEN       = 8,
    parameter int START_LEN     = 3,
    parameter int TICK_DIV      = 5000000,
    parameter int ON_TICKS      = 2,
    parameter int OFF_TICKS     = 2,
    parameter int LIVES         = 3,
    parameter int TIMEOUT_TICKS = 16
) (
    input logic clk,
    input logic reset,
    memory_game_core_if.slave bus
);

    localparam int LEN_W   = len_w(MAX_LEN);
    localparam int LIVES_W = lives_w(LIVES);
    localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX0   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TMAX    = (TIMEOUT_TICKS > TMAX0) ? TIMEOUT_TICKS : TMAX0;
    localparam int TCNT_W  = $clog2(TMAX + 1);

    game_state_t               state, state_n;
    logic [MAX_LEN*NOTE_W-1:0] seq, seq_n;
    logic                      loaded, loaded_n;
    logic [IDX_W-1:0]          idx, idx_n;
    logic [LEN_W-1:0]          len, len_n;
    logic [LIVES_W-1:0]        lives, lives_n;
    logic [NOTE_W-1:0]         cap, cap_n;
    logic                      match, match_n;
    logic [NOTE_W-1:0]         tone, tone_n;
    logic                      miss, miss_n;
    logic                      key_prev;
    logic [TCNT_W-1:0]         tcnt;

    logic              tick;
    logic              tick_clr;
    logic              press;
    logic              release_ev;
    logic              last;
    logic              start_game;
    logic              miss_now;
    logic [NOTE_W-1:0] note_cur;

    assign press      = bus.key_valid && !key_prev;
    assign release_ev = !bus.key_valid && key_prev;
    assign note_cur   = seq[idx*NOTE_W +: NOTE_W];
    assign last       = (LEN_W'(idx) == (len - LEN_W'(1)));

    // Restart the divider on entry to timed states so each phase gets whole ticks.
    assign tick_clr = (state_n != state) && ((state_n == PLAY_ON) || (state_n == WAIT_KEY));

    game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        seq_n      = seq;
        loaded_n   = loaded;
        idx_n      = idx;
        len_n      = len;
        lives_n    = lives;
        cap_n      = cap;
        match_n    = match;
        tone_n     = '0;
        miss_n     = 1'b0;
        start_game = 1'b0;
        miss_now   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.seq_load) begin
                    seq_n    = bus.seq_data;
                    loaded_n = 1'b1;
                end
                start_game = bus.start && (loaded || bus.seq_load);
            end
            PLAY_ON: begin
                tone_n = note_cur;
                if (tick && (tcnt == TCNT_W'(ON_TICKS - 1))) begin
                    state_n = PLAY_OFF;
                end
            end
            PLAY_OFF: begin
                if (tick && (tcnt == TCNT_W'(OFF_TICKS - 1))) begin
                    if (last) begin
                        idx_n   = '0;
                        state_n = WAIT_KEY;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = PLAY_ON;
                    end
                end
            end
            WAIT_KEY: begin
                if (press) begin
                    cap_n   = bus.key_code;
                    match_n = (bus.key_code == note_cur);
                    state_n = KEY_HOLD;
                end else if ((TIMEOUT_TICKS != 0) && tick &&
                             (tcnt == TCNT_W'(TIMEOUT_TICKS - 1))) begin
                    miss_now = 1'b1;
                end
            end
            KEY_HOLD: begin
                tone_n = cap;
                if (release_ev) begin
                    tone_n = '0;
                    if (!match) begin
                        miss_now = 1'b1;
                    end else if (!last) begin
                        idx_n   = idx + 1'b1;
                        state_n = WAIT_KEY;
                    end else if (len == LEN_W'(MAX_LEN)) begin
                        state_n = WIN;
                    end else begin
                        len_n   = len + LEN_W'(1);
                        idx_n   = '0;
                        state_n = PLAY_ON;
                    end
                end
            end
            WIN, LOSE: begin
                start_game = bus.start;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (start_game) begin
            len_n   = LEN_W'(START_LEN);
            lives_n = LIVES_W'(LIVES);
            idx_n   = '0;
            state_n = PLAY_ON;
        end

        if (miss_now) begin
            miss_n  = 1'b1;
            lives_n = lives - LIVES_W'(1);
            if (lives == LIVES_W'(1)) begin
                state_n = LOSE;
            end else begin
                idx_n   = '0;
                state_n = PLAY_ON;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq      <= '0;
            loaded   <= 1'b0;
            idx      <= '0;
            len      <= '0;
            lives    <= '0;
            cap      <= '0;
            match    <= 1'b0;
            tone     <= '0;
            miss     <= 1'b0;
            key_prev <= 1'b0;
            tcnt     <= '0;
        end else begin
            seq      <= seq_n;
            loaded   <= loaded_n;
            idx      <= idx_n;
            len      <= len_n;
            lives    <= lives_n;
            cap      <= cap_n;
            match    <= match_n;
            tone     <= tone_n;
            miss     <= miss_n;
            key_prev <= bus.key_valid;
            if (state_n != state) begin
                tcnt <= '0;
            end else if (tick) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign bus.tone_out   = tone;
    assign bus.led_out    = tone;
    assign bus.playing    = (state == PLAY_ON) || (state == PLAY_OFF);
    assign bus.miss_pulse = miss;
    assign bus.round_len  = len;
    assign bus.lives_left = lives;
    assign bus.game_win   = (state == WIN);
    assign bus.game_over  = (state == LOSE);

endmodule

// File: tb/tb_memory_game_core.sv
// Directed bench: small divider, 4-note sequences, hand-derived cycle-exact tone timeline.
module tb_memory_game_core;

    localparam int NOTE_W        = 4;
    localparam int MAX_LEN       = 4;
    localparam int START_LEN     = 2;
    localparam int TICK_DIV      = 2;
    localparam int ON_TICKS      = 2;
    localparam int OFF_TICKS     = 2;
    localparam int LIVES         = 3;
    localparam int TIMEOUT_TICKS = 3;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] seq_exp;

    memory_game_core_if #(.NOTE_W(NOTE_W), .MAX_LEN(MAX_LEN), .LIVES(LIVES)) bus ();

    memory_game_core #(
        .NOTE_W(NOTE_W), .MAX_LEN(MAX_LEN), .START_LEN(START_LEN), .TICK_DIV(TICK_DIV),
        .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS), .LIVES(LIVES), .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts on the first cycle of PLAY_ON; each note is 4 cycles on then 4 silent,
    // with the tone one cycle behind the state. Ends on the first WAIT_KEY cycle.
    task automatic expect_play(input int n, input logic exp_miss, input string tag);
        logic [3:0] nt;
        logic [3:0] et;
        for (int k = 0; k < n; k++) begin
            nt = seq_exp[k*4 +: 4];
            for (int j = 0; j < 8; j++) begin
                et = (j >= 1 && j <= 4) ? nt : 4'd0;
                chk($sformatf("%s tone n%0d c%0d", tag, k, j), 32'(bus.tone_out), 32'(et));
                chk($sformatf("%s led n%0d c%0d", tag, k, j), 32'(bus.led_out), 32'(et));
                chk($sformatf("%s playing n%0d c%0d", tag, k, j), 32'(bus.playing), 32'd1);
                chk($sformatf("%s miss n%0d c%0d", tag, k, j), 32'(bus.miss_pulse),
                    32'((k == 0 && j == 0) ? exp_miss : 1'b0));
                step();
            end
        end
        chk({tag, " wait playing"}, 32'(bus.playing), 32'd0);
        chk({tag, " wait tone"}, 32'(bus.tone_out), 32'd0);
    endtask

    // Called on a WAIT_KEY cycle; leaves off on the cycle after the release outcome.
    task automatic press(input logic [3:0] code, input string tag);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        step();
        step();
        chk({tag, " echo"}, 32'(bus.tone_out), 32'(code));
        bus.key_valid = 1'b0;
        step();
        chk({tag, " tone after release"}, 32'(bus.tone_out), 32'd0);
    endtask

    task automatic pulse_start(input logic load, input logic [15:0] data);
        bus.seq_data = data;
        bus.seq_load = load;
        bus.start    = 1'b1;
        step();
        bus.seq_load = 1'b0;
        bus.start    = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.seq_load  = 1'b0;
        bus.seq_data  = '0;
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = '0;
        step();
        step();
        chk("rst tone", 32'(bus.tone_out), 32'd0);
        chk("rst playing", 32'(bus.playing), 32'd0);
        chk("rst round_len", 32'(bus.round_len), 32'd0);
        chk("rst lives", 32'(bus.lives_left), 32'd0);
        chk("rst win", 32'(bus.game_win), 32'd0);
        chk("rst over", 32'(bus.game_over), 32'd0);
        reset = 1'b0;
        step();

        pulse_start(1'b0, 16'h0000);
        step();
        chk("unloaded start playing", 32'(bus.playing), 32'd0);
        chk("unloaded start len", 32'(bus.round_len), 32'd0);

        seq_exp = 16'h4321;
        pulse_start(1'b1, seq_exp);
        chk("g1 round_len", 32'(bus.round_len), 32'd2);
        chk("g1 lives", 32'(bus.lives_left), 32'd3);
        expect_play(2, 1'b0, "g1 r2");
        press(4'd1, "g1 r2 k1");
        chk("g1 r2 mid len", 32'(bus.round_len), 32'd2);
        press(4'd2, "g1 r2 k2");
        chk("g1 r3 len", 32'(bus.round_len), 32'd3);
        expect_play(3, 1'b0, "g1 r3");
        for (int i = 1; i <= 3; i++) press(4'(i), "g1 r3 key");
        chk("g1 r4 len", 32'(bus.round_len), 32'd4);
        expect_play(4, 1'b0, "g1 r4");
        for (int i = 1; i <= 4; i++) press(4'(i), "g1 r4 key");
        chk("win flag", 32'(bus.game_win), 32'd1);
        chk("win playing", 32'(bus.playing), 32'd0);
        step();
        step();
        chk("win held", 32'(bus.game_win), 32'd1);
        chk("win tone", 32'(bus.tone_out), 32'd0);

        // seq_load alongside the restart must be ignored outside IDLE.
        pulse_start(1'b1, 16'hFFFF);
        chk("g2 win cleared", 32'(bus.game_win), 32'd0);
        chk("g2 lives", 32'(bus.lives_left), 32'd3);
        expect_play(2, 1'b0, "g2 r2");

        press(4'd5, "g2 miss1");
        chk("miss1 lives", 32'(bus.lives_left), 32'd2);
        chk("miss1 len", 32'(bus.round_len), 32'd2);
        expect_play(2, 1'b1, "g2 replay1");
        press(4'd7, "g2 miss2");
        chk("miss2 lives", 32'(bus.lives_left), 32'd1);
        expect_play(2, 1'b1, "g2 replay2");
        press(4'd7, "g2 miss3");
        chk("lose flag", 32'(bus.game_over), 32'd1);
        chk("lose miss", 32'(bus.miss_pulse), 32'd1);
        chk("lose lives", 32'(bus.lives_left), 32'd0);
        chk("lose playing", 32'(bus.playing), 32'd0);
        step();
        chk("lose miss cleared", 32'(bus.miss_pulse), 32'd0);
        chk("lose held", 32'(bus.game_over), 32'd1);

        pulse_start(1'b0, 16'h0000);
        chk("g3 over cleared", 32'(bus.game_over), 32'd0);
        chk("g3 lives", 32'(bus.lives_left), 32'd3);
        expect_play(2, 1'b0, "g3 r2");
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("timeout quiet c%0d", i), 32'(bus.miss_pulse), 32'd0);
            step();
        end
        chk("timeout lives", 32'(bus.lives_left), 32'd2);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd1;
        expect_play(2, 1'b1, "g3 replay held");
        step();
        step();
        chk("held key no echo", 32'(bus.tone_out), 32'd0);
        bus.key_valid = 1'b0;
        step();
        press(4'd1, "g3 repress k1");
        press(4'd2, "g3 k2");
        chk("g3 r3 len", 32'(bus.round_len), 32'd3);
        step();
        step();
        chk("g3 r3 tone on", 32'(bus.tone_out), 32'd1);

        #2 reset = 1'b1;
        #1;
        chk("async rst tone", 32'(bus.tone_out), 32'd0);
        chk("async rst playing", 32'(bus.playing), 32'd0);
        chk("async rst len", 32'(bus.round_len), 32'd0);
        chk("async rst lives", 32'(bus.lives_left), 32'd0);
        step();
        reset = 1'b0;
        step();
        pulse_start(1'b0, 16'h0000);
        step();
        chk("post rst start ignored", 32'(bus.playing), 32'd0);

        seq_exp = 16'h00A0;
        pulse_start(1'b1, seq_exp);
        expect_play(2, 1'b0, "g4 r2");
        press(4'd0, "g4 k0");
        press(4'd10, "g4 kA");
        chk("g4 r3 len", 32'(bus.round_len), 32'd3);
        chk("g4 lives", 32'(bus.lives_left), 32'd3);
        expect_play(3, 1'b0, "g4 r3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
